// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the multiply/divide sequencer
package muldiv_pkg;

    localparam int TIMEOUT_CYCLES_DEFAULT = 40;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MULT_RUN = 3'd1,
        ST_DIV_RUN  = 3'd2,
        ST_WRITE    = 3'd3,
        ST_DONE     = 3'd4,
        ST_EXC      = 3'd5
    } state_t;

    typedef enum logic {
        CAUSE_DIV_ZERO = 1'b0,
        CAUSE_TIMEOUT  = 1'b1
    } cause_t;

    localparam logic SEL_MULT = 1'b0;
    localparam logic SEL_DIV  = 1'b1;

endpackage

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - run-state cycle counter that flags the last allowed cycle
module cycle_timer #(
    parameter int LIMIT = 40
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int WIDTH = $clog2(LIMIT + 1);
    localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);
    localparam logic [WIDTH-1:0] MAX  = WIDTH'(LIMIT);

    logic [WIDTH-1:0] count;

    // Count enabled cycles since the last clear, saturating at LIMIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != MAX)) begin
            count <= count + WIDTH'(1);
        end
    end

    // The cycle being sampled now is the LIMIT-th enabled cycle: the count
    // reaches LIMIT on this edge.
    assign expired = enable && (count == LAST);

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - sequencer for the multiply/divide units and the HI/LO write
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic req_mult,
    input  logic req_div,
    input  logic mult_stop,
    input  logic div_stop,
    input  logic div_zero,
    output logic mult_start,
    output logic div_start,
    output logic hilo_select,
    output logic hilo_write,
    output logic busy,
    output logic done,
    output logic exc,
    output logic exc_cause
);

    state_t state;
    state_t state_n;

    logic   timer_clear;
    logic   timer_enable;
    logic   timer_expired;

    logic   mult_start_n;
    logic   div_start_n;
    logic   sel_n;
    cause_t cause_n;

    assign timer_enable = (state == ST_MULT_RUN) || (state == ST_DIV_RUN);

    cycle_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode; a stop flag always beats the timeout, and in a
    // divide a zero divisor beats a normal stop.
    always_comb begin
        state_n      = state;
        timer_clear  = 1'b0;
        mult_start_n = 1'b0;
        div_start_n  = 1'b0;
        sel_n        = hilo_select;
        cause_n      = CAUSE_DIV_ZERO;
        unique case (state)
            ST_IDLE: begin
                if (req_mult) begin
                    state_n      = ST_MULT_RUN;
                    mult_start_n = 1'b1;
                    timer_clear  = 1'b1;
                end else if (req_div) begin
                    state_n      = ST_DIV_RUN;
                    div_start_n  = 1'b1;
                    timer_clear  = 1'b1;
                end
            end
            ST_MULT_RUN: begin
                if (mult_stop) begin
                    state_n = ST_WRITE;
                    sel_n   = SEL_MULT;
                end else if (timer_expired) begin
                    state_n = ST_EXC;
                    cause_n = CAUSE_TIMEOUT;
                end
            end
            ST_DIV_RUN: begin
                if (div_zero) begin
                    state_n = ST_EXC;
                    cause_n = CAUSE_DIV_ZERO;
                end else if (div_stop) begin
                    state_n = ST_WRITE;
                    sel_n   = SEL_DIV;
                end else if (timer_expired) begin
                    state_n = ST_EXC;
                    cause_n = CAUSE_TIMEOUT;
                end
            end
            ST_WRITE: state_n = ST_DONE;
            ST_DONE:  state_n = ST_IDLE;
            ST_EXC:   state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // Output registers, loaded from the state being entered so each output
    // lines up with the cycle its state is occupied.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mult_start  <= 1'b0;
            div_start   <= 1'b0;
            hilo_select <= 1'b0;
            hilo_write  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            exc         <= 1'b0;
            exc_cause   <= 1'b0;
        end else begin
            mult_start  <= mult_start_n;
            div_start   <= div_start_n;
            hilo_select <= sel_n;
            hilo_write  <= (state_n == ST_WRITE);
            busy        <= (state_n != ST_IDLE);
            done        <= (state_n == ST_DONE);
            exc         <= (state_n == ST_EXC);
            exc_cause   <= (state_n == ST_EXC) ? cause_n : 1'b0;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - self-checking bench for muldiv_ctrl
module tb_muldiv_ctrl;

    localparam int TO = 40;

    logic clk = 1'b0;
    logic reset;
    logic req_mult, req_div, mult_stop, div_stop, div_zero;
    logic mult_start, div_start, hilo_select, hilo_write, busy, done, exc, exc_cause;

    always #5 clk = ~clk;

    muldiv_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_mult    (req_mult),
        .req_div     (req_div),
        .mult_stop   (mult_stop),
        .div_stop    (div_stop),
        .div_zero    (div_zero),
        .mult_start  (mult_start),
        .div_start   (div_start),
        .hilo_select (hilo_select),
        .hilo_write  (hilo_write),
        .busy        (busy),
        .done        (done),
        .exc         (exc),
        .exc_cause   (exc_cause)
    );

    logic [7:0] dut_vec;
    assign dut_vec = {mult_start, div_start, hilo_select, hilo_write, busy, done, exc, exc_cause};

    int n_checks = 0;
    int n_pass   = 0;

    // model: operation in flight, cycles it has run, outputs still owed
    logic [7:0] exp_vec = '0;
    int         m_op    = 0;
    int         m_len   = 0;
    logic       sel_hold = 1'b0;
    logic [7:0] tail[$];

    // monitor
    int cyc = 0;
    int n_ms = 0, n_ds = 0, n_wr = 0, n_dn = 0, n_ex = 0;
    int t_ms = 0, t_ds = 0, t_wr = 0, t_dn = 0, t_ex = 0;
    int last_sel = 0, last_cause = 0;
    int b_ms, b_ds, b_wr, b_dn, b_ex;

    function automatic logic [7:0] mk(input logic ms, input logic ds, input logic wr,
                                      input logic bz, input logic dn, input logic ex,
                                      input logic cs);
        return {ms, ds, sel_hold, wr, bz, dn, ex, cs};
    endfunction

    task automatic model_proc();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_op = 0;
                m_len = 0;
                sel_hold = 1'b0;
                tail.delete();
                exp_vec = '0;
            end else if (tail.size() != 0) begin
                exp_vec = tail.pop_front();
            end else if (m_op == 0) begin
                if (req_mult) begin
                    m_op = 1; m_len = 0; exp_vec = mk(1, 0, 0, 1, 0, 0, 0);
                end else if (req_div) begin
                    m_op = 2; m_len = 0; exp_vec = mk(0, 1, 0, 1, 0, 0, 0);
                end else begin
                    exp_vec = mk(0, 0, 0, 0, 0, 0, 0);
                end
            end else begin
                m_len = m_len + 1;
                if (m_op == 2 && div_zero) begin
                    exp_vec = mk(0, 0, 0, 1, 0, 1, 0);
                    tail.push_back(mk(0, 0, 0, 0, 0, 0, 0));
                    m_op = 0;
                end else if ((m_op == 1 && mult_stop) || (m_op == 2 && div_stop)) begin
                    sel_hold = (m_op == 2);
                    exp_vec = mk(0, 0, 1, 1, 0, 0, 0);
                    tail.push_back(mk(0, 0, 0, 1, 1, 0, 0));
                    tail.push_back(mk(0, 0, 0, 0, 0, 0, 0));
                    m_op = 0;
                end else if (m_len == TO) begin
                    exp_vec = mk(0, 0, 0, 1, 0, 1, 1);
                    tail.push_back(mk(0, 0, 0, 0, 0, 0, 0));
                    m_op = 0;
                end else begin
                    exp_vec = mk(0, 0, 0, 1, 0, 0, 0);
                end
            end
        end
    endtask

    task automatic count_proc();
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    endtask

    task automatic monitor_proc();
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (mult_start) begin n_ms++; t_ms = cyc; end
                if (div_start)  begin n_ds++; t_ds = cyc; end
                if (hilo_write) begin n_wr++; t_wr = cyc; last_sel = int'(hilo_select); end
                if (done)       begin n_dn++; t_dn = cyc; end
                if (exc)        begin n_ex++; t_ex = cyc; last_cause = int'(exc_cause); end
            end
        end
    endtask

    task automatic cycle_compare();
        logic [7:0] mask;
        forever begin
            @(negedge clk);
            mask = exp_vec[1] ? 8'hFF : 8'hFE;
            n_checks++;
            if ((dut_vec & mask) === (exp_vec & mask)) n_pass++;
            else $display("FAIL cycle %0d outputs {ms,ds,sel,wr,busy,done,exc,cause}: got %b expected %b",
                          cyc, dut_vec, exp_vec);
        end
    endtask

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    task automatic snap();
        b_ms = n_ms; b_ds = n_ds; b_wr = n_wr; b_dn = n_dn; b_ex = n_ex;
    endtask

    task automatic issue(input logic m, input logic d);
        @(negedge clk);
        req_mult = m; req_div = d;
        @(negedge clk);
        req_mult = 1'b0; req_div = 1'b0;
    endtask

    // Called right after issue(): the flags are sampled k edges after the request edge.
    task automatic flag_at(input int k, input logic ms, input logic ds, input logic dz);
        repeat (k - 1) @(negedge clk);
        mult_stop = ms; div_stop = ds; div_zero = dz;
        @(negedge clk);
        mult_stop = 1'b0; div_stop = 1'b0; div_zero = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int i;
        i = 0;
        while (busy && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk({name, " returns idle"}, int'(busy), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_counts(input string name, input int ms, input int ds, input int wr,
                              input int dn, input int ex);
        chk({name, " mult_start pulses"}, n_ms - b_ms, ms);
        chk({name, " div_start pulses"},  n_ds - b_ds, ds);
        chk({name, " hilo_write cycles"}, n_wr - b_wr, wr);
        chk({name, " done pulses"},       n_dn - b_dn, dn);
        chk({name, " exc pulses"},        n_ex - b_ex, ex);
    endtask

    initial begin
        reset = 1'b1;
        req_mult = 1'b0; req_div = 1'b0;
        mult_stop = 1'b0; div_stop = 1'b0; div_zero = 1'b0;
        fork
            model_proc();
            count_proc();
            monitor_proc();
            begin
                #200000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1);
            end
        join_none
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset outputs", int'(dut_vec), 0);
        fork
            cycle_compare();
        join_none

        // multiply, stop sampled 33 edges after the request
        snap(); issue(1, 0); flag_at(33, 1, 0, 0); wait_idle("mult33");
        chk_counts("mult33", 1, 0, 1, 1, 0);
        chk("mult33 write latency", t_wr - t_ms, 33);
        chk("mult33 done latency", t_dn - t_ms, 34);
        chk("mult33 select", last_sel, 0);

        // both requests together, divide re-requested during the multiply
        snap(); issue(1, 1); req_div = 1'b1; flag_at(10, 1, 0, 0); req_div = 1'b0;
        wait_idle("both");
        chk_counts("both", 1, 0, 1, 1, 0);

        // divide, normal stop after 7
        snap(); issue(0, 1); flag_at(7, 0, 1, 0); wait_idle("div7");
        chk_counts("div7", 0, 1, 1, 1, 0);
        chk("div7 write latency", t_wr - t_ds, 7);
        chk("div7 select", last_sel, 1);
        chk("div7 select held in idle", int'(hilo_select), 1);

        // divide-by-zero after 5
        snap(); issue(0, 1); flag_at(5, 0, 0, 1); wait_idle("divzero");
        chk_counts("divzero", 0, 1, 0, 0, 1);
        chk("divzero exc latency", t_ex - t_ds, 5);
        chk("divzero cause", last_cause, 0);

        // div_zero and div_stop together
        snap(); issue(0, 1); flag_at(3, 0, 1, 1); wait_idle("zero+stop");
        chk_counts("zero+stop", 0, 1, 0, 0, 1);
        chk("zero+stop cause", last_cause, 0);

        // divide timeout
        snap(); issue(0, 1); wait_idle("divtimeout");
        chk_counts("divtimeout", 0, 1, 0, 0, 1);
        chk("divtimeout exc latency", t_ex - t_ds, 40);
        chk("divtimeout cause", last_cause, 1);

        // stop on the timeout cycle wins
        snap(); issue(0, 1); flag_at(40, 0, 1, 0); wait_idle("div40stop");
        chk_counts("div40stop", 0, 1, 1, 1, 0);
        chk("div40stop write latency", t_wr - t_ds, 40);

        // multiply ignores divider flags, then times out
        snap(); issue(1, 0); flag_at(2, 0, 1, 1); wait_idle("multtimeout");
        chk_counts("multtimeout", 1, 0, 0, 0, 1);
        chk("multtimeout exc latency", t_ex - t_ms, 40);
        chk("multtimeout cause", last_cause, 1);

        // asynchronous reset in the middle of a divide
        snap(); issue(0, 1);
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1 chk("async reset outputs", int'(dut_vec), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        div_stop = 1'b1;
        @(negedge clk);
        div_stop = 1'b0;
        repeat (50) @(negedge clk);
        chk_counts("reset mid-div", 0, 1, 0, 0, 0);
        chk("reset mid-div busy", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 40, maximum cycles allowed in a run state before aborting.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: req_mult  input  1  control-unit request to start a multiply (level, sampled in IDLE only).
REQ-005 Port: req_div  input  1  control-unit request to start a divide (level, sampled in IDLE only).
REQ-006 Port: mult_stop  input  1  multiplier completion flag.
REQ-007 Port: div_stop  input  1  divider completion flag.
REQ-008 Port: div_zero  input  1  divider divide-by-zero flag.
REQ-009 Port: mult_start  output  1  one-cycle start pulse to multiplier.
REQ-010 Port: div_start  output  1  one-cycle start pulse to divider.
REQ-011 Port: hilo_select  output  1  HI/LO source mux select; 0 = multiplier, 1 = divider.
REQ-012 Port: hilo_write  output  1  HI/LO register write enable.
REQ-013 Port: busy  output  1  high in every state except IDLE.
REQ-014 Port: done  output  1  one-cycle pulse on successful completion.
REQ-015 Port: exc  output  1  one-cycle pulse on abort.
REQ-016 Port: exc_cause  output  1  abort cause, valid while exc high: 0 = divide-by-zero, 1 = timeout.

Function
REQ-017 The FSM SHALL have states IDLE, MULT_RUN, DIV_RUN, WRITE, DONE, EXC; all outputs SHALL be registered.
REQ-018 IDLE with req_mult=1 at edge N: the FSM SHALL enter MULT_RUN, and mult_start SHALL be 1 for cycle N+1 only.
REQ-019 IDLE with req_div=1 and req_mult=0: the FSM SHALL enter DIV_RUN, and div_start SHALL be 1 for one cycle.
REQ-020 If req_mult and req_div are both 1 in IDLE, multiply SHALL win and the divide request SHALL be dropped.
REQ-021 Requests in any non-IDLE state SHALL be ignored; there is no queueing.
REQ-022 MULT_RUN: mult_stop=1 -> WRITE with hilo_select=0; div_stop and div_zero SHALL be ignored.
REQ-023 DIV_RUN: div_zero=1 -> EXC with cause 0 and no HI/LO write; otherwise div_stop=1 -> WRITE with hilo_select=1.
REQ-024 div_zero and div_stop high in the same cycle SHALL be treated as div_zero.
REQ-025 A cycle counter SHALL clear on entry to a run state and increment every run cycle.
REQ-026 If the counter reaches TIMEOUT_CYCLES with no stop, the FSM SHALL enter EXC with cause 1.
REQ-027 A stop flag in the same cycle as the counter reaching TIMEOUT_CYCLES SHALL take priority over timeout.
REQ-028 WRITE SHALL hold hilo_write=1 for exactly one cycle, then go to DONE.
REQ-029 DONE SHALL pulse done for one cycle, then go to IDLE.
REQ-030 EXC SHALL pulse exc for one cycle, then go to IDLE.
REQ-031 hilo_select SHALL hold its last value outside WRITE.
REQ-032 Minimum latency SHALL be: request edge N; stop sampled at edge N+k; hilo_write in cycle N+k+1; done in cycle N+k+2.

Reset
REQ-033 Asserting reset SHALL immediately force IDLE, counter 0, and all outputs 0 (including hilo_select), including mid-operation.
REQ-034 No write, done or exc SHALL be emitted for an operation interrupted by reset.

Structure
REQ-035 Package muldiv_pkg SHALL hold the state encoding enum, cause codes, and the TIMEOUT_CYCLES default.
REQ-036 The timeout counter SHALL be a sub-module cycle_timer (inputs clear, enable; output expired), sized ceil(log2(TIMEOUT_CYCLES+1)) bits.

Verification
REQ-037 req_mult=1, mult_stop high 33 cycles later -> one mult_start pulse, hilo_select=0, one hilo_write cycle, then done, busy back to 0.
REQ-038 req_div=1, div_zero=1 after 5 cycles -> exc=1, exc_cause=0, hilo_write never asserted.
REQ-039 req_mult=1 and req_div=1 together -> only mult_start pulses; a second req_div during MULT_RUN produces no div_start.
REQ-040 req_div with no stop, TIMEOUT_CYCLES=40 -> exc=1, exc_cause=1 exactly 40 cycles after entering DIV_RUN; same-cycle div_stop instead yields WRITE.
REQ-041 reset asserted asynchronously mid-DIV_RUN -> all outputs 0 immediately, state IDLE, no later done, exc or hilo_write.
